imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 118 +++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: assembles little-endian 32-bit words from an
// 8-bit valid/ready stream, writes them to instruction memory and holds the core in reset until done.
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [ADDR_WIDTH:0]   LENGTH,
  input  logic [7:0]            RX_DATA,
  input  logic                  RX_VALID,
  output logic                  RX_READY,
  output logic                  IW_WE,
  output logic [ADDR_WIDTH-1:0] IW_ADDR,
  output logic [DATA_WIDTH-1:0] IW_DATA,
  output logic                  CORE_RESET_N,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output logic [31:0]           CHECKSUM,
  output logic [1:0]            DBG_STATE
);

  // Handshake: a byte moves on a rising CLK edge where RX_VALID and RX_READY are both 1;
  // RX_READY is registered and never depends combinationally on RX_VALID.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t              state;
  logic [1:0]          byte_cnt;
  logic [23:0]         shift_q;
  logic [ADDR_WIDTH:0] word_idx;
  logic [ADDR_WIDTH:0] length_q;
  logic                last_q;
  logic                accept;

  assign accept       = (state == S_LOAD) && RX_READY && RX_VALID;
  assign BUSY         = (state == S_LOAD);
  assign DONE         = (state == S_DONE);
  assign CORE_RESET_N = (state == S_DONE);
  assign DBG_STATE    = state;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      RX_READY <= 1'b0;
      IW_WE    <= 1'b0;
      IW_ADDR  <= '0;
      IW_DATA  <= '0;
      ERR      <= 1'b0;
      CHECKSUM <= '0;
      byte_cnt <= '0;
      shift_q  <= '0;
      word_idx <= '0;
      length_q <= '0;
      last_q   <= 1'b0;
    end else begin
      IW_WE <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            if (LENGTH == '0) begin
              state    <= S_DONE;
              ERR      <= 1'b0;
              CHECKSUM <= '0;
            end else if (LENGTH > MAX_LEN) begin
              state <= S_IDLE;
              ERR   <= 1'b1;
            end else begin
              state    <= S_LOAD;
              ERR      <= 1'b0;
              CHECKSUM <= '0;
              byte_cnt <= '0;
              word_idx <= '0;
              length_q <= LENGTH;
              last_q   <= 1'b0;
              RX_READY <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              IW_WE    <= 1'b1;
              IW_ADDR  <= word_idx[ADDR_WIDTH-1:0];
              IW_DATA  <= DATA_WIDTH'({RX_DATA, shift_q});
              word_idx <= word_idx + ONE;
              if (word_idx == length_q - ONE) begin
                RX_READY <= 1'b0;
                last_q   <= 1'b1;
              end
            end else begin
              // Shift right so the first byte ends up in bits 7:0.
              shift_q <= {RX_DATA, shift_q[23:8]};
            end
          end
          if (IW_WE) begin
            CHECKSUM <= CHECKSUM + IW_DATA[31:0];
            if (last_q) begin
              state <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
